// File: rtl/cnn_argmax_collector.sv
// Collects one frame of five per-class scores and emits a signed argmax on an AXI-stream output.
// Define ARGMAX_ALL_SCORES_EN to add pred_all_TDATA, which carries all five scores with the result.
module cnn_argmax_collector #(
  parameter int unsigned PIXEL_BIT_WIDTH    = 16,
  parameter int unsigned CLASS_BITWIDTH     = 3,
  parameter int unsigned FRAME_CNT_BITWIDTH = 16
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [PIXEL_BIT_WIDTH-1:0]    cnn_output_0_TDATA,
  input  logic                          cnn_output_0_TVALID,
  output logic                          cnn_output_0_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]    cnn_output_1_TDATA,
  input  logic                          cnn_output_1_TVALID,
  output logic                          cnn_output_1_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]    cnn_output_2_TDATA,
  input  logic                          cnn_output_2_TVALID,
  output logic                          cnn_output_2_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]    cnn_output_3_TDATA,
  input  logic                          cnn_output_3_TVALID,
  output logic                          cnn_output_3_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]    cnn_output_4_TDATA,
  input  logic                          cnn_output_4_TVALID,
  output logic                          cnn_output_4_TREADY,
  output logic [CLASS_BITWIDTH-1:0]     pred_class_TDATA,
  output logic [PIXEL_BIT_WIDTH-1:0]    pred_score_TDATA,
  output logic                          pred_TVALID,
  input  logic                          pred_TREADY,
`ifdef ARGMAX_ALL_SCORES_EN
  output logic [FRAME_CNT_BITWIDTH-1:0] frame_count,
  output logic [5*PIXEL_BIT_WIDTH-1:0]  pred_all_TDATA
`else
  output logic [FRAME_CNT_BITWIDTH-1:0] frame_count
`endif
);

  localparam int unsigned NUM_CLASSES = 5;
  localparam int unsigned IDX_W       = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {COLLECT, COMPARE, EMIT} state_t;

  state_t                     state, state_next;
  logic [PIXEL_BIT_WIDTH-1:0] tdata     [NUM_CLASSES];
  logic [PIXEL_BIT_WIDTH-1:0] score_reg [NUM_CLASSES];
  logic [NUM_CLASSES-1:0]     tvalid, tready, captured, capture;
  logic                       all_in, pred_fire, cmp_better;
  logic [PIXEL_BIT_WIDTH-1:0] best, best_next, cand;
  logic [IDX_W-1:0]           best_idx, best_idx_next, cmp_idx;

  assign tdata[0] = cnn_output_0_TDATA;
  assign tdata[1] = cnn_output_1_TDATA;
  assign tdata[2] = cnn_output_2_TDATA;
  assign tdata[3] = cnn_output_3_TDATA;
  assign tdata[4] = cnn_output_4_TDATA;
  assign tvalid   = {cnn_output_4_TVALID, cnn_output_3_TVALID, cnn_output_2_TVALID,
                     cnn_output_1_TVALID, cnn_output_0_TVALID};
  assign cnn_output_0_TREADY = tready[0];
  assign cnn_output_1_TREADY = tready[1];
  assign cnn_output_2_TREADY = tready[2];
  assign cnn_output_3_TREADY = tready[3];
  assign cnn_output_4_TREADY = tready[4];

  assign capture   = tvalid & tready;
  assign all_in    = &(captured | capture);
  assign pred_fire = pred_TVALID & pred_TREADY;

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= COLLECT;
    else           state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (all_in)              state_next = COMPARE;
      COMPARE: if (cmp_idx == LAST_IDX) state_next = EMIT;
      EMIT:    if (pred_fire)           state_next = COLLECT;
      default:                          state_next = COLLECT;
    endcase
  end

  // Ready is held low during reset so nothing upstream sees a spurious accept
  always_comb begin
    tready = '0;
    if (ap_rst_n && state == COLLECT) tready = ~captured;
  end

  // One comparison per cycle; strict greater-than keeps the lower index on ties
  always_comb begin
    cand = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (cmp_idx == IDX_W'(k)) cand = score_reg[k];
    end
    cmp_better    = $signed(cand) > $signed(best);
    best_next     = cmp_better ? cand : best;
    best_idx_next = cmp_better ? cmp_idx : best_idx;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int k = 0; k < NUM_CLASSES; k++) score_reg[k] <= '0;
      captured         <= '0;
      best             <= '0;
      best_idx         <= '0;
      cmp_idx          <= '0;
      pred_TVALID      <= 1'b0;
      pred_class_TDATA <= '0;
      pred_score_TDATA <= '0;
      frame_count      <= '0;
`ifdef ARGMAX_ALL_SCORES_EN
      pred_all_TDATA   <= '0;
`endif
    end else begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        if (capture[k]) score_reg[k] <= tdata[k];
      end
      case (state)
        COLLECT: begin
          captured <= captured | capture;
          if (all_in) begin
            best     <= capture[0] ? tdata[0] : score_reg[0];
            best_idx <= '0;
            cmp_idx  <= IDX_W'(1);
          end
        end
        COMPARE: begin
          best     <= best_next;
          best_idx <= best_idx_next;
          cmp_idx  <= cmp_idx + IDX_W'(1);
          if (cmp_idx == LAST_IDX) begin
            pred_TVALID      <= 1'b1;
            pred_class_TDATA <= CLASS_BITWIDTH'(best_idx_next);
            pred_score_TDATA <= best_next;
`ifdef ARGMAX_ALL_SCORES_EN
            for (int k = 0; k < NUM_CLASSES; k++) begin
              pred_all_TDATA[k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] <= score_reg[k];
            end
`endif
          end
        end
        EMIT: begin
          if (pred_fire) begin
            pred_TVALID <= 1'b0;
            captured    <= '0;
            frame_count <= frame_count + FRAME_CNT_BITWIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_argmax_collector.sv
// Bench for cnn_argmax_collector: table vectors, hand-written corner sequences and randomized frames.
// Frame counter is built narrow so the wrap-around is reached in a short run.
module tb_cnn_argmax_collector;

  localparam int unsigned PW   = 16;
  localparam int unsigned CW   = 3;
  localparam int unsigned FCW  = 8;
  localparam int unsigned FMOD = 1 << FCW;

  typedef logic [4:0][PW-1:0] frame_t;
  typedef struct packed {
    frame_t          s;
    logic [CW-1:0]   cls;
    logic [PW-1:0]   sc;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] d [5];
  logic [4:0]    v;
  wire  [4:0]    r;
  wire  [CW-1:0] pcls;
  wire  [PW-1:0] pscore;
  wire           pvalid;
  logic          pready;
  wire  [FCW-1:0] fcnt;
`ifdef ARGMAX_ALL_SCORES_EN
  wire  [5*PW-1:0] pall;
`endif

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  cnn_argmax_collector #(
    .PIXEL_BIT_WIDTH(PW), .CLASS_BITWIDTH(CW), .FRAME_CNT_BITWIDTH(FCW)
  ) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .cnn_output_0_TDATA(d[0]), .cnn_output_0_TVALID(v[0]), .cnn_output_0_TREADY(r[0]),
    .cnn_output_1_TDATA(d[1]), .cnn_output_1_TVALID(v[1]), .cnn_output_1_TREADY(r[1]),
    .cnn_output_2_TDATA(d[2]), .cnn_output_2_TVALID(v[2]), .cnn_output_2_TREADY(r[2]),
    .cnn_output_3_TDATA(d[3]), .cnn_output_3_TVALID(v[3]), .cnn_output_3_TREADY(r[3]),
    .cnn_output_4_TDATA(d[4]), .cnn_output_4_TVALID(v[4]), .cnn_output_4_TREADY(r[4]),
    .pred_class_TDATA(pcls), .pred_score_TDATA(pscore),
    .pred_TVALID(pvalid), .pred_TREADY(pready),
`ifdef ARGMAX_ALL_SCORES_EN
    .frame_count(fcnt),
    .pred_all_TDATA(pall)
`else
    .frame_count(fcnt)
`endif
  );

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: largest signed value, lowest index among equals
  function automatic void ref_argmax(input frame_t s, output logic [CW-1:0] c,
                                     output logic [PW-1:0] sc);
    int mx;
    mx = -(1 << 20);
    for (int k = 0; k < 5; k++) if (int'($signed(s[k])) > mx) mx = int'($signed(s[k]));
    c = '0;
    for (int k = 4; k >= 0; k--) if (int'($signed(s[k])) == mx) c = CW'(k);
    sc = PW'(mx);
  endfunction

  function automatic vec_t mk(input logic [PW-1:0] a0, a1, a2, a3, a4,
                              input int c, input logic [PW-1:0] sc);
    vec_t m;
    m.s[0] = a0; m.s[1] = a1; m.s[2] = a2; m.s[3] = a3; m.s[4] = a4;
    m.cls  = CW'(c);
    m.sc   = sc;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Delivers one frame (channel k first offered at cycle st[k]), waits for the result,
  // optionally stalls the consumer, then completes the handshake.
  task automatic do_frame(input frame_t s, input int st [5], input int stall,
                          input logic [CW-1:0] ec, input logic [PW-1:0] es);
    logic [4:0] pend, hs;
    int cyc, lat, mxs;
    pend = '1;
    cyc  = 0;
    mxs  = 0;
    for (int k = 0; k < 5; k++) if (st[k] > mxs) mxs = st[k];
    while (pend != 5'b0 && cyc < 40) begin
      for (int k = 0; k < 5; k++) begin
        v[k] = (cyc >= st[k]);
        d[k] = pend[k] ? s[k] : PW'($urandom);
      end
      hs = v & r;
      step();
      cyc++;
      pend = pend & ~hs;
      chk("tready_vs_pending", 80'(r), 80'(pend));
    end
    v = '0;
    chk("capture_cycles", 80'(cyc), 80'(mxs + 1));
    lat = 0;
    while (!pvalid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", 80'(lat), 80'(4));
    chk("pred_class", 80'(pcls), 80'(ec));
    chk("pred_score", 80'(pscore), 80'(es));
`ifdef ARGMAX_ALL_SCORES_EN
    chk("pred_all", 80'(pall), 80'(s));
`endif
    for (int i = 0; i < stall; i++) begin
      pready = 1'b0;
      v      = '1;
      for (int k = 0; k < 5; k++) d[k] = PW'($urandom);
      step();
      chk("stall_valid", 80'(pvalid), 80'(1));
      chk("stall_class", 80'(pcls), 80'(ec));
      chk("stall_score", 80'(pscore), 80'(es));
      chk("stall_tready", 80'(r), 80'(0));
    end
    v      = '0;
    pready = 1'b1;
    step();
    pready  = 1'b0;
    exp_cnt = (exp_cnt + 1) % FMOD;
    chk("valid_after_hs", 80'(pvalid), 80'(0));
    chk("frame_count", 80'(fcnt), 80'(exp_cnt));
    chk("tready_after_hs", 80'(r), 80'(5'h1f));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t       vt [8];
    int         st [5];
    frame_t     fr;
    logic [CW-1:0] ec;
    logic [PW-1:0] es;

    vt[0] = mk(16'd5, 16'd3, 16'd9, 16'hFFFE, 16'd1, 2, 16'd9);
    vt[1] = mk(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 16'd0);
    vt[2] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8001, 4, 16'h8001);
    vt[3] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 16'h7FFF);
    vt[4] = mk(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1, 16'h0000);
    vt[5] = mk(16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 3, 16'h7FFF);
    vt[6] = mk(16'hFFF9, 16'hFFFD, 16'hFFFD, 16'hFFF6, 16'hFFFB, 1, 16'hFFFD);
    vt[7] = mk(16'h1234, 16'hFFFF, 16'h1234, 16'h0001, 16'h1235, 4, 16'h1235);

    rst_n  = 1'b0;
    v      = '0;
    pready = 1'b0;
    for (int k = 0; k < 5; k++) d[k] = '0;
    #12;
    chk("rst_tready", 80'(r), 80'(0));
    chk("rst_valid", 80'(pvalid), 80'(0));
    chk("rst_class", 80'(pcls), 80'(0));
    chk("rst_score", 80'(pscore), 80'(0));
    chk("rst_count", 80'(fcnt), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("tready_out_of_reset", 80'(r), 80'(5'h1f));

    // Table vectors: all channels valid together
    st = '{0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) do_frame(vt[i].s, st, 0, vt[i].cls, vt[i].sc);

    // Serial arrival in order 4,0,3,1,2 with a tie between classes 1 and 2
    st = '{1, 3, 4, 2, 0};
    do_frame(vt[6].s, st, 0, 3'd1, 16'hFFFD);

    // Consumer stalled for 20 cycles while every producer keeps offering data
    st = '{0, 0, 0, 0, 0};
    do_frame(vt[5].s, st, 20, 3'd3, 16'h7FFF);

    // Randomized frames, arrival skew and back-pressure
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 5; k++) begin
        fr[k] = (i % 4 == 0) ? PW'($urandom_range(0, 3)) : PW'($urandom);
        st[k] = int'($urandom_range(0, 3));
      end
      ref_argmax(fr, ec, es);
      do_frame(fr, st, int'($urandom_range(0, 3)), ec, es);
    end

    // Reset after three of five scores captured
    v = 5'b00111;
    d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333;
    step();
    v = '0;
    chk("partial_tready", 80'(r), 80'(5'b11000));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tready", 80'(r), 80'(0));
    chk("mid_rst_valid", 80'(pvalid), 80'(0));
    chk("mid_rst_class", 80'(pcls), 80'(0));
    chk("mid_rst_score", 80'(pscore), 80'(0));
    chk("mid_rst_count", 80'(fcnt), 80'(0));
`ifdef ARGMAX_ALL_SCORES_EN
    chk("mid_rst_all", 80'(pall), 80'(0));
`endif
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 0;
    step();
    chk("post_rst_tready", 80'(r), 80'(5'h1f));
    fr[0] = 16'd1; fr[1] = 16'd2; fr[2] = 16'd3; fr[3] = 16'd4; fr[4] = 16'h7FFF;
    st = '{0, 0, 0, 0, 0};
    do_frame(fr, st, 0, 3'd4, 16'h7FFF);

    // Back-to-back frames until the counter wraps (FMOD+1 frames since reset)
    for (int i = 0; i < int'(FMOD); i++) begin
      for (int k = 0; k < 5; k++) fr[k] = PW'($urandom);
      ref_argmax(fr, ec, es);
      do_frame(fr, st, 0, ec, es);
    end
    chk("count_wrapped", 80'(fcnt), 80'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
